// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver: one-hot FSM state
// encoding, parity mode constants and counter width helper.
package uart_pkg;

  typedef enum logic [5:0] {
    ST_IDLE      = 6'b000001,
    ST_START     = 6'b000010,
    ST_DATA      = 6'b000100,
    ST_PARITY    = 6'b001000,
    ST_STOP      = 6'b010000,
    ST_WAIT_IDLE = 6'b100000
  } state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic int cnt_width(input int range_val);
    return (range_val > 1) ? $clog2(range_val) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Input synchroniser plus 3-sample majority voter around the bit centre;
// emits one bit_val/bit_strobe decision per bit period.
module uart_rx_sampler #(
  parameter int OVERSAMPLE = 16,
  parameter int TW         = 4
) (
  input  logic          i_clock,
  input  logic          i_reset_n,
  input  logic          i_tick,
  input  logic          i_rx,
  input  logic [TW-1:0] i_tcnt,
  output logic          o_rx_s,
  output logic          o_bit_val,
  output logic          o_bit_strobe
);

  localparam int M = OVERSAMPLE / 2;
  localparam logic [TW-1:0] T_EARLY  = TW'(M - 1);
  localparam logic [TW-1:0] T_CENTRE = TW'(M);
  localparam logic [TW-1:0] T_LATE   = TW'(M + 1);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic smp0_q, smp0_d;
  logic smp1_q, smp1_d;

  // NOTE: every variable gets a default at the top of always_comb, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    sync1_d = i_rx;
    sync2_d = sync1_q;
    smp0_d  = smp0_q;
    smp1_d  = smp1_q;
    if (i_tick && (i_tcnt == T_EARLY))  smp0_d = sync2_q;
    if (i_tick && (i_tcnt == T_CENTRE)) smp1_d = sync2_q;
  end

  // The third sample is the live synchronised value on the decision tick.
  assign o_rx_s       = sync2_q;
  assign o_bit_strobe = i_tick && (i_tcnt == T_LATE);
  assign o_bit_val    = (smp0_q & smp1_q) | (smp0_q & sync2_q) | (smp1_q & sync2_q);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      smp0_q  <= 1'b1;
      smp1_q  <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      smp0_q  <= smp0_d;
      smp1_q  <= smp1_d;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: frame FSM, shift register, parity accumulator
// and registered frame outputs with one o_valid pulse per frame.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic                 i_tick,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int TW = cnt_width(OVERSAMPLE);
  localparam int IW = cnt_width(DATA_BITS);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] I_LAST = IW'(DATA_BITS - 1);
  localparam logic          S_LAST = 1'(STOP_BITS - 1);

  state_e               state_q, state_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [IW-1:0]        bidx_q, bidx_d;
  logic                 sidx_q, sidx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 ferr_acc_q, ferr_acc_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 frame_q, frame_d;
  logic                 busy_q, busy_d;

  logic rx_s, bit_val, bit_strobe;
  logic period_end, done, parity_bad;

  uart_rx_sampler #(
    .OVERSAMPLE(OVERSAMPLE),
    .TW        (TW)
  ) u_sampler (
    .i_clock     (i_clock),
    .i_reset_n   (i_reset_n),
    .i_tick      (i_tick),
    .i_rx        (i_rx),
    .i_tcnt      (tcnt_q),
    .o_rx_s      (rx_s),
    .o_bit_val   (bit_val),
    .o_bit_strobe(bit_strobe)
  );

  assign period_end = i_tick && (tcnt_q == T_LAST);
  assign done       = (state_q == ST_STOP) && bit_strobe && (sidx_q == S_LAST);

  always_comb begin
    case (PARITY)
      PAR_ODD:  parity_bad = ~par_q;
      PAR_EVEN: parity_bad = par_q;
      default:  parity_bad = 1'b0;
    endcase
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d    = state_q;
    tcnt_d     = tcnt_q;
    bidx_d     = bidx_q;
    sidx_d     = sidx_q;
    shift_d    = shift_q;
    par_d      = par_q;
    ferr_acc_d = ferr_acc_q;
    if (i_tick) tcnt_d = (tcnt_q == T_LAST) ? '0 : tcnt_q + TW'(1);

    case (state_q)
      ST_IDLE: begin
        tcnt_d = '0;
        if (i_tick && !rx_s) begin
          state_d    = ST_START;
          tcnt_d     = TW'(1);
          par_d      = 1'b0;
          ferr_acc_d = 1'b0;
        end
      end
      ST_START: begin
        if (bit_strobe && bit_val) begin
          state_d = ST_IDLE;
          tcnt_d  = '0;
        end else if (period_end) begin
          state_d = ST_DATA;
          bidx_d  = '0;
        end
      end
      ST_DATA: begin
        if (bit_strobe) begin
          shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
          par_d   = par_q ^ bit_val;
        end
        if (period_end) begin
          if (bidx_q == I_LAST) begin
            state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            sidx_d  = 1'b0;
          end else begin
            bidx_d = bidx_q + IW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_strobe) par_d = par_q ^ bit_val;
        if (period_end) begin
          state_d = ST_STOP;
          sidx_d  = 1'b0;
        end
      end
      ST_STOP: begin
        if (bit_strobe) begin
          ferr_acc_d = ferr_acc_q | ~bit_val;
          // Final stop bit ends the frame at its centre, leaving half a
          // bit of slack before a back-to-back start edge.
          if (sidx_q == S_LAST) begin
            state_d = bit_val ? ST_IDLE : ST_WAIT_IDLE;
            tcnt_d  = '0;
          end
        end else if (period_end) begin
          sidx_d = sidx_q + 1'b1;
        end
      end
      ST_WAIT_IDLE: begin
        tcnt_d = '0;
        if (i_tick && rx_s) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        tcnt_d  = '0;
      end
    endcase
  end

  // Registered outputs, loaded together on frame completion.
  always_comb begin
    busy_d  = !((state_d == ST_IDLE) || (state_d == ST_WAIT_IDLE));
    valid_d = done;
    data_d  = done ? shift_q : data_q;
    perr_d  = done ? parity_bad : perr_q;
    frame_d = done ? (ferr_acc_q | ~bit_val) : frame_q;
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      tcnt_q     <= '0;
      bidx_q     <= '0;
      sidx_q     <= 1'b0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      ferr_acc_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      frame_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      tcnt_q     <= tcnt_d;
      bidx_q     <= bidx_d;
      sidx_q     <= sidx_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      ferr_acc_q <= ferr_acc_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      frame_q    <= frame_d;
      busy_q     <= busy_d;
    end
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_parity_err = perr_q;
  assign o_frame_err  = frame_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: three configurations (8N1, 8E1, 7N2)
// sharing clock, tick and reset, each with its own serial line.
module tb_uart_rx_cfg;
  import uart_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, tick;
  logic rx_a, rx_p, rx_s7;

  logic [7:0] data_a, data_p;
  logic [6:0] data_s;
  logic valid_a, perr_a, ferr_a, busy_a;
  logic valid_p, perr_p, ferr_p, busy_p;
  logic valid_s, perr_s, ferr_s, busy_s;

  uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1)) dut_a (
    .i_clock(clk), .i_reset_n(rst_n), .i_tick(tick), .i_rx(rx_a),
    .o_data(data_a), .o_valid(valid_a), .o_parity_err(perr_a),
    .o_frame_err(ferr_a), .o_busy(busy_a)
  );

  uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(2), .STOP_BITS(1)) dut_p (
    .i_clock(clk), .i_reset_n(rst_n), .i_tick(tick), .i_rx(rx_p),
    .o_data(data_p), .o_valid(valid_p), .o_parity_err(perr_p),
    .o_frame_err(ferr_p), .o_busy(busy_p)
  );

  uart_rx_cfg #(.DATA_BITS(7), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(2)) dut_s (
    .i_clock(clk), .i_reset_n(rst_n), .i_tick(tick), .i_rx(rx_s7),
    .o_data(data_s), .o_valid(valid_s), .o_parity_err(perr_s),
    .o_frame_err(ferr_s), .o_busy(busy_s)
  );

  int checks   = 0;
  int failures = 0;

  // Pulse and busy monitors, sampled on the falling edge.
  int   vcnt_a = 0, vcnt_p = 0, vcnt_s = 0, busy_cyc_a = 0;
  logic prev_busy_a = 1'b0, fall_valid_a = 1'b0;

  always @(negedge clk) begin
    if (valid_a) vcnt_a <= vcnt_a + 1;
    if (valid_p) vcnt_p <= vcnt_p + 1;
    if (valid_s) vcnt_s <= vcnt_s + 1;
    if (busy_a)  busy_cyc_a <= busy_cyc_a + 1;
    if (prev_busy_a && !busy_a) fall_valid_a <= valid_a;
    prev_busy_a <= busy_a;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One tick period: a cycle with i_tick high followed by one with it low.
  task automatic step();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic set_line(input int sel, input logic v);
    case (sel)
      0:       rx_a  = v;
      1:       rx_p  = v;
      default: rx_s7 = v;
    endcase
  endtask

  task automatic send_bit(input int sel, input logic v);
    set_line(sel, v);
    repeat (16) step();
  endtask

  // Bits go out LSB first; bit 0 is normally the start bit.
  task automatic send_frame(input int sel, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) send_bit(sel, bits[i]);
  endtask

  int v0, b0;

  initial begin
    rst_n = 1'b0;
    tick  = 1'b0;
    rx_a  = 1'b1;
    rx_p  = 1'b1;
    rx_s7 = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_data",  32'(data_a),  32'h0);
    check("rst_valid", 32'(valid_a), 32'h0);
    check("rst_perr",  32'(perr_a),  32'h0);
    check("rst_ferr",  32'(ferr_a),  32'h0);
    check("rst_busy",  32'(busy_a),  32'h0);
    check("rst_busy_s", 32'(busy_s), 32'h0);
    rst_n = 1'b1;
    idle(4);

    // 8N1 0xA5
    v0 = vcnt_a;
    send_frame(0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10);
    idle(4);
    #1;
    check("a5_count", 32'(vcnt_a - v0), 32'd1);
    check("a5_data",  32'(data_a), 32'hA5);
    check("a5_perr",  32'(perr_a), 32'h0);
    check("a5_ferr",  32'(ferr_a), 32'h0);
    check("a5_busy_fall_with_valid", 32'(fall_valid_a), 32'h1);

    // Even parity: 0x3C with wrong parity bit, then correct one
    v0 = vcnt_p;
    send_frame(1, {5'b0, 1'b1, 1'b1, 8'h3C, 1'b0}, 11);
    idle(4);
    #1;
    check("par_bad_count", 32'(vcnt_p - v0), 32'd1);
    check("par_bad_data",  32'(data_p), 32'h3C);
    check("par_bad_perr",  32'(perr_p), 32'h1);
    check("par_bad_ferr",  32'(ferr_p), 32'h0);
    send_frame(1, {5'b0, 1'b1, 1'b0, 8'h3C, 1'b0}, 11);
    idle(4);
    #1;
    check("par_ok_count", 32'(vcnt_p - v0), 32'd2);
    check("par_ok_perr",  32'(perr_p), 32'h0);

    // False start: line low for 4 ticks
    v0 = vcnt_a;
    b0 = busy_cyc_a;
    set_line(0, 1'b0);
    repeat (4) step();
    set_line(0, 1'b1);
    idle(32);
    #1;
    check("glitch_count",      32'(vcnt_a - v0), 32'd0);
    check("glitch_busy_pulse", 32'(busy_cyc_a > b0), 32'h1);
    check("glitch_busy_now",   32'(busy_a), 32'h0);
    check("glitch_fall_no_valid", 32'(fall_valid_a), 32'h0);
    send_frame(0, {6'b0, 1'b1, 8'h55, 1'b0}, 10);
    idle(4);
    #1;
    check("x55_count", 32'(vcnt_a - v0), 32'd1);
    check("x55_data",  32'(data_a), 32'h55);

    // 0xFF with a one-tick low spike at the centre of data bit 3
    v0 = vcnt_a;
    send_frame(0, {12'b0, 3'b111, 1'b0}, 4);
    set_line(0, 1'b1);
    repeat (8) step();
    set_line(0, 1'b0);
    step();
    set_line(0, 1'b1);
    repeat (7) step();
    send_frame(0, {11'b0, 1'b1, 4'hF}, 5);
    idle(4);
    #1;
    check("spike_count", 32'(vcnt_a - v0), 32'd1);
    check("spike_data",  32'(data_a), 32'hFF);
    check("spike_perr",  32'(perr_a), 32'h0);
    check("spike_ferr",  32'(ferr_a), 32'h0);

    // 7N2 with second stop bit low, then a held break
    v0 = vcnt_s;
    send_frame(2, {6'b0, 1'b0, 1'b1, 7'h15, 1'b0}, 10);
    #1;
    check("stop2_count", 32'(vcnt_s - v0), 32'd1);
    check("stop2_data",  32'(data_s), 32'h15);
    check("stop2_ferr",  32'(ferr_s), 32'h1);
    check("stop2_state", 32'(dut_s.state_q), 32'(ST_WAIT_IDLE));
    check("stop2_busy",  32'(busy_s), 32'h0);
    repeat (480) step();
    #1;
    check("break_count", 32'(vcnt_s - v0), 32'd1);
    check("break_state", 32'(dut_s.state_q), 32'(ST_WAIT_IDLE));
    set_line(2, 1'b1);
    idle(20);
    send_frame(2, {6'b0, 2'b11, 7'h2A, 1'b0}, 10);
    idle(4);
    #1;
    check("x2a_count", 32'(vcnt_s - v0), 32'd2);
    check("x2a_data",  32'(data_s), 32'h2A);
    check("x2a_ferr",  32'(ferr_s), 32'h0);

    // Reset during data bit 4 of 0x81
    v0 = vcnt_a;
    send_frame(0, {11'b0, 4'b0001, 1'b0}, 5);
    set_line(0, 1'b0);
    repeat (8) step();
    #1;
    check("midrst_busy_before", 32'(busy_a), 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    set_line(0, 1'b1);
    #1;
    check("midrst_data",  32'(data_a),  32'h0);
    check("midrst_valid", 32'(valid_a), 32'h0);
    check("midrst_perr",  32'(perr_a),  32'h0);
    check("midrst_ferr",  32'(ferr_a),  32'h0);
    check("midrst_busy",  32'(busy_a),  32'h0);
    idle(200);
    #1;
    check("midrst_no_frame", 32'(vcnt_a - v0), 32'd0);
    send_frame(0, {6'b0, 1'b1, 8'h81, 1'b0}, 10);
    idle(4);
    #1;
    check("x81_count", 32'(vcnt_a - v0), 32'd1);
    check("x81_data",  32'(data_a), 32'h81);
    check("x81_ferr",  32'(ferr_a), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver: the next-generation replacement for the fixed 8N1 receiver in the serial path. It adds configurable data width, parity, stop-bit count and oversampling ratio, majority-vote bit sampling, an input synchroniser, false-start rejection, and parity/framing error reporting. It sits between the baud-rate tick generator and the byte consumer (ALU/interface FSM), and delivers one `o_valid` pulse per received frame.

## Interface
- `DATA_BITS`, 8: data bits per frame; legal 5..9.
- `OVERSAMPLE`, 16: `i_tick` pulses per bit period; even, ≥ 8.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: stop bits checked; 1 or 2.
- `i_clock`  in  1  system clock; all logic on its rising edge.
- `i_reset_n`  in  1  reset; synchronous and active-low.
- `i_tick`  in  1  oversample enable, one-cycle pulse; high every cycle is legal.
- `i_rx`  in  1  asynchronous serial line; idles high.
- `o_data`  out  DATA_BITS  received word, LSB = first bit on the line.
- `o_valid`  out  1  one-cycle pulse: frame complete, `o_data` and error flags updated.
- `o_parity_err`  out  1  parity mismatch on last frame (always 0 when PARITY = 0).
- `o_frame_err`  out  1  any sampled stop bit was 0 on last frame.
- `o_busy`  out  1  high in every state except IDLE and WAIT_IDLE.

## Operation
- `i_rx` passes through a 2-flop synchroniser (both flops reset to 1) to give `rx_s`. All decisions use `rx_s`.
- Bit counter `tcnt` (width clog2(OVERSAMPLE)) advances only on cycles with `i_tick` high.
- Let `M` = OVERSAMPLE/2. The bit value is the majority of `rx_s` sampled on the ticks where `tcnt` = M-1, M and M+1. The decision is taken on the tick where `tcnt` = M+1.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE: on a tick with `rx_s` = 0 → START, with `tcnt` = 0 on that tick.
- START:
  - Majority = 1 → IDLE (glitch, no output).
  - Majority = 0 → continue to the end of the period (`tcnt` = OVERSAMPLE-1), then DATA, with the bit index at 0.
- DATA: shift in one bit per period, LSB first. After bit DATA_BITS-1 → PARITY if PARITY ≠ 0, else STOP.
- PARITY: sample one bit.
  - Odd: error if XOR(data, bit) = 0.
  - Even: error if XOR(data, bit) = 1.
- STOP: sample STOP_BITS bits; frame error if any sample is 0.
  - At the decision tick of the final stop bit, do not wait for the end of the period.
  - Line high at that decision → IDLE. This permits back-to-back frames with half a bit of slack.
  - Line low (break or bad stop) → WAIT_IDLE.
- WAIT_IDLE: stay until a tick with `rx_s` = 1, then IDLE. A held break therefore yields exactly one frame.
- Completion: on the clock after the final stop decision, `o_data`, `o_parity_err` and `o_frame_err` load together and `o_valid` is high for exactly one cycle.
  - Outputs hold until the next completion.
  - Frames with errors are still delivered, with `o_valid` high.
- Reset (`i_reset_n` = 0 at an edge), including mid-frame:
  - State → IDLE, counters → 0, synchroniser → 1.
  - `o_data`, `o_valid`, both error flags and `o_busy` → 0 after that edge.
  - No partial frame is ever emitted.

## Timing
- Synchroniser latency: 2 clocks from `i_rx` to `rx_s`.
- `o_valid` rises 1 clock after the `i_tick` cycle holding the final stop decision.
- Frame length to `o_valid`, in ticks: (1 + DATA_BITS + (PARITY≠0)) × OVERSAMPLE + (STOP_BITS-1) × OVERSAMPLE + M + 2.
- No backpressure: the consumer must take `o_data` within one frame time. The next `o_valid` overwrites it.
- `o_busy` is registered and changes on the same edge as the state register.

## Structure
- Shared package `uart_pkg`:
  - State encoding constants (one-hot, 6 bits).
  - Parity mode constants `PAR_NONE`, `PAR_ODD`, `PAR_EVEN`.
  - Function computing the counter width from OVERSAMPLE.
- Sub-module `uart_rx_sampler` contains:
  - The 2-flop synchroniser.
  - The 3-sample majority voter, which outputs `rx_s` plus a `bit_val`/`bit_strobe` pair per period.
- The top level holds the FSM, shift register, parity accumulator and output registers.
- Next-state logic and all registered updates are separated. No latches: every combinational path assigns in every branch.

## Test plan
- 8N1, OVERSAMPLE = 16, send 0xA5 → exactly one `o_valid`; `o_data` = 0xA5, both errors 0; `o_busy` falls on the same edge as `o_valid`.
- PARITY = 2, send 0x3C with parity bit 1 (wrong) → `o_data` = 0x3C, `o_parity_err` = 1. Next frame 0x3C with parity bit 0 → `o_parity_err` = 0.
- Line low for 4 ticks then high → no `o_valid`; `o_busy` pulses and returns to 0. A following 0x55 frame is received correctly.
- Single-tick low spike at `tcnt` = M inside a '1' data bit of 0xFF → majority corrects; `o_data` = 0xFF, no errors.
- DATA_BITS = 7, STOP_BITS = 2, second stop bit driven 0 → `o_frame_err` = 1 and state WAIT_IDLE. Holding the line low for 3 frame times gives no further `o_valid`. After release, 0x2A is received cleanly.
- Assert `i_reset_n` = 0 for 1 cycle during data bit 4 → all outputs 0 on the next edge, no `o_valid`. The next full frame 0x81 is received correctly.
